// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sample types, reorder bank states and bit-reverse helper
package fft_pkg;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } complex_t;
  typedef struct packed {
    logic signed [2*DATA_WIDTH-1:0] re;
    logic signed [2*DATA_WIDTH-1:0] im;
  } complex_product_t;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} reorder_bank_state_e;
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < width) r[i] = value[5'(width - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_buffer_bank.sv
// reorder_bank: N-entry sample memory, registered write port, combinational read port
module reorder_bank #(
  parameter int N = 8,
  parameter int W = 64,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer: ping-pong buffer turning bit-reversed FFT frames into natural order.
// Define FFT_REORDER_SCALE_EN to divide each output component by N (IFFT normalisation).
module fft_reorder_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N = 8,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  complex_product_t in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output complex_product_t out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             err_frame
);
  localparam int W = 4 * DATA_WIDTH;
  reorder_bank_state_e state [2];
  logic wr_bank, rd_bank;
  logic [LOG2N-1:0] wr_cnt, rd_cnt, wr_idx, wr_addr;
  logic accept, resync, wr_last, xfer, rd_last;
  logic [W-1:0] rdata [2];
  complex_product_t raw;
  assign in_ready = state[wr_bank] inside {EMPTY, FILLING};
  assign accept = in_valid && in_ready;
  // a start-of-frame mid-frame restarts the frame at index 0
  assign resync = accept && in_sof && wr_cnt != '0;
  assign wr_idx = resync ? '0 : wr_cnt;
  assign wr_addr = LOG2N'(bitrev(32'(wr_idx), LOG2N));
  assign wr_last = accept && wr_idx == LOG2N'(N - 1);
  assign out_valid = state[rd_bank] inside {FULL, DRAINING};
  assign xfer = out_valid && out_ready;
  assign rd_last = xfer && rd_cnt == LOG2N'(N - 1);
  assign out_sof = out_valid && rd_cnt == '0;
  assign out_eof = out_valid && rd_cnt == LOG2N'(N - 1);
  assign raw = rdata[rd_bank];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(.N(N), .W(W)) u_bank (
      .clk   (clk),
      .we    (accept && wr_bank == 1'(b)),
      .waddr (wr_addr),
      .wdata (in_data),
      .raddr (rd_cnt),
      .rdata (rdata[b])
    );
  end
  // write and read banks never coincide while both are active
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      err_frame <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt         <= wr_last ? '0 : wr_idx + 1'b1;
        state[wr_bank] <= wr_last ? FULL : FILLING;
        wr_bank        <= wr_bank ^ wr_last;
      end
      if (resync) err_frame <= 1'b1;
      if (xfer) begin
        rd_cnt         <= rd_last ? '0 : rd_cnt + 1'b1;
        state[rd_bank] <= rd_last ? EMPTY : DRAINING;
        rd_bank        <= rd_bank ^ rd_last;
      end
    end
`ifdef FFT_REORDER_SCALE_EN
  always_comb begin
    out_data    = raw;
    out_data.re = raw.re >>> LOG2N;
    out_data.im = raw.im >>> LOG2N;
  end
`else
  assign out_data = raw;
`endif
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// tb_fft_reorder_buffer: scoreboard bench for the bit-reversed to natural-order buffer
module tb_fft_reorder_buffer;
  import fft_pkg::*;
  localparam int N = 8;
  localparam int LOG2N = 3;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  complex_product_t in_data = '0, out_data;
  logic in_ready, out_valid, out_sof, out_eof, err_frame;
  int n_vec = 0, n_err = 0;
  complex_product_t exp_q[$];
  complex_product_t part [N];
  int pcnt = 0, ocnt = 0, cyc = 0, n_out = 0, first_out = -1, last_out = -1;
  logic stall_seen = 1'b0;

  always #5 clk = ~clk;

  fft_reorder_buffer #(.DATA_WIDTH(16), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .err_frame (err_frame)
  );

  function automatic int brev(int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic complex_product_t scale(complex_product_t d);
    complex_product_t s = d;
`ifdef FFT_REORDER_SCALE_EN
    s.re = d.re >>> LOG2N;
    s.im = d.im >>> LOG2N;
`endif
    return s;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: sample k of a frame belongs to natural bin bitrev(k)
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      pcnt = 0;
      ocnt = 0;
    end else begin
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (in_valid && in_ready) begin
        if (in_sof && pcnt != 0) pcnt = 0;
        part[brev(pcnt)] = in_data;
        pcnt++;
        if (pcnt == N) begin
          for (int i = 0; i < N; i++) exp_q.push_back(scale(part[i]));
          pcnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_queue_size", 64'(exp_q.size()), 64'd1);
        else begin
          check("out_data", out_data, exp_q.pop_front());
          check("out_sof", out_sof, ocnt == 0);
          check("out_eof", out_eof, ocnt == N - 1);
        end
        ocnt = (ocnt + 1) % N;
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
  end

  task automatic push(int re, int im, logic sof);
    int t = 0;
    in_valid = 1'b1;
    in_data.re = re;
    in_data.im = im;
    in_sof = sof;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t == 100) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic send_frame(int base, logic sof);
    for (int k = 0; k < N; k++) push(base + brev(k), base * 2 + 1000 - brev(k), sof && k == 0);
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(posedge clk);
    #1;
    check("drain_done", 64'(exp_q.size()), 64'd0);
    check("idle_after_drain", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_err_frame", err_frame, 0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    // single frame: 0,4,2,6,1,5,3,7 in, 0..7 out
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      push(brev(k), 50 + k, k == 0);
      if (k < N - 1) check("t1_no_early_valid", out_valid, 0);
    end
    check("t1_latency", out_valid, 1);
    check("t1_first_sof", out_sof, 1);
    drain();
    // back-to-back frames at full rate
    stall_seen = 1'b0;
    n_out = 0;
    first_out = -1;
    for (int f = 0; f < 4; f++) send_frame(16 * (f + 1), 1'b0);
    drain();
    check("t2_no_stall", stall_seen, 0);
    check("t2_count", 64'(n_out), 64'd32);
    check("t2_contiguous", 64'(last_out - first_out), 64'd31);
    check("t2_no_err", err_frame, 0);
    // downstream stalled while three frames are offered
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_sof = 1'b0;
      in_data.re = 300 + 100 * (idx / N) + brev(idx % N);
      in_data.im = idx;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t3_accepted", 64'(idx), 64'd16);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_sof", out_sof, 1);
    check("t3_hold_bin0", out_data, exp_q[0]);
    drain();
    // resync: sof on the 4th sample
    for (int k = 0; k < 3; k++) push(500 + brev(k), 7, k == 0);
    check("t4_err_before", err_frame, 0);
    for (int k = 0; k < N; k++) begin
      push(600 + brev(k), 9 + k, k == 0);
      if (k == 0) check("t4_err_set", err_frame, 1);
    end
    drain();
    check("t4_err_sticky", err_frame, 1);
    // reset mid-drain at rd_cnt 3
    out_ready = 1'b0;
    send_frame(700, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t5_bin3_pending", out_data, exp_q[0]);
    reset = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_err_clr", err_frame, 0);
    check("t5_out_valid", out_valid, 0);
    out_ready = 1'b1;
    send_frame(800, 1'b1);
    drain();
`ifdef FFT_REORDER_SCALE_EN
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) push(k == 0 ? -9 : 40 * k, k == 0 ? 16 : -24 * k, k == 0);
    check("scale_re", 64'($signed(out_data.re)), 64'(-2));
    check("scale_im", 64'($signed(out_data.im)), 64'(2));
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fft_reorder_buffer.md
Name: fft_reorder_buffer

Overview:
- Sits downstream of the radix-2 delay-commutator FFT pipeline (top_all).
- Accepts one frame of N bit-reversed-order FFT results (complex_product_t), one sample per cycle.
- Emits each frame in natural order through a valid/ready stream.
- Ping-pong double buffer: one bank fills while the other drains, sustaining 1 sample/cycle.

Parameters:
DATA_WIDTH, 16, real/imag width of FFT input samples; complex_product_t fields are 2*DATA_WIDTH.
N, 8, FFT size, power of two, >= 4; address width LOG2N = $clog2(N).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  input sample valid.
in_ready  output  1  buffer can accept a sample this cycle.
in_sof  input  1  first sample of a frame; qualified by in_valid.
in_data  input  complex_product_t  FFT output sample, bit-reversed order.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts the sample.
out_data  output  complex_product_t  natural-order sample.
out_sof  output  1  out_data is bin 0.
out_eof  output  1  out_data is bin N-1.
err_frame  output  1  sticky flag: a frame was resynchronised; cleared only by reset.

Behaviour:
- Storage: two banks (0/1) of N entries. Each bank has state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Reset (reset low, async): both banks EMPTY, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, err_frame=0. out_valid/out_sof/out_eof=0. in_ready=1 once reset deasserts.
- Reset mid-operation discards all buffered data. Memory contents are not cleared.
- Write side:
  - in_ready = bank[wr_bank] is EMPTY or FILLING, from registered state only.
  - An input is accepted when in_valid && in_ready. It is written at address bitrev(wr_cnt) of bank[wr_bank], and wr_cnt increments.
  - The first accept moves the bank EMPTY->FILLING.
  - An accept with wr_cnt==N-1 moves the bank to FULL, toggles wr_bank and clears wr_cnt.
- Resync:
  - If an accepted sample has in_sof=1 and wr_cnt!=0, the partial frame is discarded. The sample is written at address 0, wr_cnt becomes 1, and err_frame sets.
  - in_sof=0 with wr_cnt==0 is accepted as a frame start, with no error.
- Read side:
  - out_valid = 1 while bank[rd_bank] is FULL or DRAINING.
  - out_data = bank[rd_bank][rd_cnt], combinational read.
  - out_sof = out_valid && rd_cnt==0; out_eof = out_valid && rd_cnt==N-1.
  - A transfer occurs on out_valid && out_ready. The first transfer moves FULL->DRAINING, and rd_cnt increments on each transfer.
  - A transfer at rd_cnt==N-1 moves the bank to EMPTY, toggles rd_bank and clears rd_cnt.
  - out_data/out_valid hold stable while out_ready=0.
- Latency: first natural-order sample is valid the cycle after the edge that accepts the frame's last input (N cycles after the first input at full rate).
- Throughput: with in_valid and out_ready held high, the input never stalls. A bank freed at edge k is writable from the cycle after edge k.
- Simultaneous events:
  - Write-complete into one bank and read-complete of the other on the same edge are both honoured.
  - Write and read never target the same bank in the same cycle.
- Full: both banks FULL/DRAINING -> in_ready=0 until the drain completes.
- Empty: both banks EMPTY/FILLING -> out_valid=0.

Optional Feature:
- Macro: FFT_REORDER_SCALE_EN.
- Defined: out_data real and imag are each arithmetic-right-shifted by LOG2N (divide by N, rounding toward -inf), for IFFT normalisation. This is combinational on the read path, with no added latency.
- Undefined: out_data is the stored sample unmodified.

Decomposition:
- Shared package fft_pkg:
  - reorder_bank_state_e enum (EMPTY, FILLING, FULL, DRAINING).
  - function bitrev(value, width).
  - complex_t/complex_product_t stay in the shared headers.
- Sub-module reorder_bank: one N-entry memory with registered write port (bit-reversed address computed by the parent) and combinational read port. Instantiated twice.

Test Plan:
- Single frame, N=8, inputs in bit-reversed order (values 0,4,2,6,1,5,3,7 written as the real parts), out_ready=1 -> out_data real = 0..7 in order. out_sof on 0, out_eof on 7. First out_valid the cycle after the 8th accept.
- Back-to-back 4 frames, in_valid=1, out_ready=1 -> in_ready never drops; 32 outputs in natural order, contiguous after the first frame.
- out_ready=0 for 20 cycles while 3 frames are offered -> 2 frames accepted, in_ready=0 afterwards. out_data holds bin 0 of frame 1. Releasing out_ready drains in order with no loss.
- in_sof asserted on the 4th sample of a frame -> err_frame=1 from the next cycle; the first 3 samples are dropped; the frame restarts with that sample as bit-reversed index 0.
- Assert reset mid-drain at rd_cnt=3 -> out_valid=0 immediately (async). After release in_ready=1, err_frame=0, and the next frame outputs correctly.
- FFT_REORDER_SCALE_EN defined, input real=-9, imag=16 at bin 0 (N=8) -> output real=-2, imag=2.
